// File: rtl/abs_enc_poll_sched.sv
// Round-robin SSI poller: one shift engine shared across NUM_CH absolute encoders,
// shadow bank copied to pos_out once per sweep. Optional parity check: ABS_ENC_PARITY_EN.
module abs_enc_poll_sched #(
    parameter int NUM_CH   = 16,
    parameter int DATA_W   = 16,
    parameter int CLK_DIV  = 25,
    parameter int MONO_CYC = 500
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     freeze,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH-1:0]        ssi_data,
    output logic                     ssi_clk,
    output logic [NUM_CH-1:0]        ssi_cs_n,
    output logic [NUM_CH*DATA_W-1:0] pos_out,
    output logic [NUM_CH-1:0]        upd_flags,
    output logic [NUM_CH-1:0]        err_flags,
    output logic                     sweep_done,
    output logic                     busy
);
`ifdef ABS_ENC_PARITY_EN
    localparam int NBIT = DATA_W + 1;
`else
    localparam int NBIT = DATA_W;
`endif
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_MAX = (CLK_DIV > MONO_CYC) ? CLK_DIV : MONO_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(NBIT + 1);

    typedef enum logic [2:0] {IDLE, SELECT, SHIFT, STORE, RECOVER, COPY_WAIT} state_t;

    state_t                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [BIT_W-1:0]                 bit_q, bit_d;
    logic                             phase_q, phase_d;
    logic [NBIT-1:0]                  sr_q, sr_d;
    logic [NUM_CH-1:0][DATA_W-1:0]    shadow_q, shadow_d;
    logic [NUM_CH-1:0][DATA_W-1:0]    pos_q, pos_d;
    logic [NUM_CH-1:0]                shd_upd_q, shd_upd_d;
    logic [NUM_CH-1:0]                upd_q, upd_d;
    logic                             done_q, done_d;
    logic                             ssi_clk_q, ssi_clk_d;
    logic [NUM_CH-1:0]                cs_n_q, cs_n_d;
    logic [NUM_CH-1:0]                sync1_q, sync2_q;
`ifdef ABS_ENC_PARITY_EN
    logic [NUM_CH-1:0]                shd_err_q, shd_err_d;
    logic [NUM_CH-1:0]                err_q, err_d;
`endif

    // {found, index} of the lowest set mask bit at or above 'from'
    function automatic logic [IDX_W:0] find_set(input logic [NUM_CH-1:0] m, input int from);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (i >= from && m[i]) r = {1'b1, IDX_W'(i)};
        return r;
    endfunction

    logic [IDX_W:0]    lo_sel, up_sel;
    logic [DATA_W-1:0] word;
    logic              word_ok;

    assign lo_sel = find_set(ch_mask, 0);
    assign up_sel = find_set(ch_mask, int'(idx_q) + 1);
    assign word   = sr_q[NBIT-1 -: DATA_W];
`ifdef ABS_ENC_PARITY_EN
    assign word_ok = ((^word) == sr_q[0]);
`else
    assign word_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        sr_d      = sr_q;
        shadow_d  = shadow_q;
        pos_d     = pos_q;
        shd_upd_d = shd_upd_q;
        upd_d     = upd_q;
        done_d    = 1'b0;
`ifdef ABS_ENC_PARITY_EN
        shd_err_d = shd_err_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable && lo_sel[IDX_W]) begin
                    state_d = SELECT;
                    idx_d   = lo_sel[IDX_W-1:0];
                    cnt_d   = '0;
                end
            end
            SELECT: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        // last cycle of the high phase: take the synchronised bit
                        sr_d    = {sr_q[NBIT-2:0], sync2_q[idx_q]};
                        phase_d = 1'b0;
                        if (bit_q == BIT_W'(NBIT - 1)) state_d = STORE;
                        else                            bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STORE: begin
                if (word_ok) begin
                    shadow_d[idx_q]  = word;
                    shd_upd_d[idx_q] = 1'b1;
                end
`ifdef ABS_ENC_PARITY_EN
                else begin
                    shd_err_d[idx_q] = 1'b1;
                end
`endif
                state_d = RECOVER;
                cnt_d   = '0;
            end
            RECOVER: begin
                if (cnt_q == CNT_W'(MONO_CYC - 1)) begin
                    cnt_d = '0;
                    if (enable && up_sel[IDX_W]) begin
                        state_d = SELECT;
                        idx_d   = up_sel[IDX_W-1:0];
                    end else begin
                        state_d = COPY_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COPY_WAIT: begin
                if (!freeze) begin
                    for (int k = 0; k < NUM_CH; k++)
                        if (shd_upd_q[k]) pos_d[k] = shadow_q[k];
                    upd_d     = shd_upd_q;
                    shd_upd_d = '0;
                    done_d    = 1'b1;
`ifdef ABS_ENC_PARITY_EN
                    err_d     = shd_err_q;
                    shd_err_d = '0;
`endif
                    cnt_d = '0;
                    if (enable && lo_sel[IDX_W]) begin
                        state_d = SELECT;
                        idx_d   = lo_sel[IDX_W-1:0];
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Pins are decoded from next state so they register in step with the FSM
        ssi_clk_d = !(state_d == SHIFT && !phase_d);
        cs_n_d    = (state_d == SELECT || state_d == SHIFT) ? ~(NUM_CH'(1) << idx_d) : '1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            phase_q   <= 1'b0;
            sr_q      <= '0;
            shadow_q  <= '0;
            pos_q     <= '0;
            shd_upd_q <= '0;
            upd_q     <= '0;
            done_q    <= 1'b0;
            ssi_clk_q <= 1'b1;
            cs_n_q    <= '1;
            sync1_q   <= '0;
            sync2_q   <= '0;
`ifdef ABS_ENC_PARITY_EN
            shd_err_q <= '0;
            err_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            sr_q      <= sr_d;
            shadow_q  <= shadow_d;
            pos_q     <= pos_d;
            shd_upd_q <= shd_upd_d;
            upd_q     <= upd_d;
            done_q    <= done_d;
            ssi_clk_q <= ssi_clk_d;
            cs_n_q    <= cs_n_d;
            sync1_q   <= ssi_data;
            sync2_q   <= sync1_q;
`ifdef ABS_ENC_PARITY_EN
            shd_err_q <= shd_err_d;
            err_q     <= err_d;
`endif
        end
    end

    assign ssi_clk    = ssi_clk_q;
    assign ssi_cs_n   = cs_n_q;
    assign pos_out    = pos_q;
    assign upd_flags  = upd_q;
    assign sweep_done = done_q;
    assign busy       = (state_q != IDLE);
`ifdef ABS_ENC_PARITY_EN
    assign err_flags  = err_q;
`else
    assign err_flags  = '0;
`endif

endmodule
